// File: rtl/ps2_rx_fifo_if.sv
// Consumer-facing bundle for ps2_rx_fifo: raw PS/2 pad lines, the FIFO read handshake and error status.
// The master side drives the pads and pops bytes. The slave side is the receiver.
interface ps2_rx_fifo_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [2:0] err_status;
    logic       err_clear;

    modport master (
        output ps2_clk, ps2_data, rd_ready, err_clear,
        input  rd_data, rd_valid, err_status
    );

    modport slave (
        input  ps2_clk, ps2_data, rd_ready, err_clear,
        output rd_data, rd_valid, err_status
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a glitch filter, a frame timeout and a first-word fall-through byte FIFO.
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity and flag them in err_status[0].
module ps2_rx_fifo #(
    parameter int FIFO_AW        = 3,
    parameter int FILT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic          clk,
    input  logic          reset_,
    ps2_rx_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FCW   = (FILT_CYCLES    > 1) ? $clog2(FILT_CYCLES + 1)    : 1;
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic           ps2_clk_s1_q, ps2_clk_s2_q, ps2_dat_s1_q, ps2_dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           fall;

    logic [1:0]     state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           push_q, push_d;
    logic [7:0]     push_data_q, push_data_d;
    logic [2:0]     err_set;
    logic [2:0]     err_q, err_d;

    logic [7:0]     mem_q [DEPTH];
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic           full, pop, wr_en, ovf;
    logic           rd_valid_q, rd_valid_d;
    logic [7:0]     rd_data_q, rd_data_d;

    // Filtered clock flips only once the synchronized input has disagreed for FILT_CYCLES samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall       = 1'b0;
        if (ps2_clk_s2_q != filt_q) begin
            if (filt_cnt_q == FCW'(FILT_CYCLES - 1)) begin
                filt_d = ps2_clk_s2_q;
                fall   = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        err_set     = 3'b000;
        to_cnt_d    = (state_q == ST_IDLE || fall) ? '0 : to_cnt_q + 1'b1;

        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!ps2_dat_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {ps2_dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: begin
                    par_d   = ps2_dat_s2_q;
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    if (!ps2_dat_s2_q) begin
                        err_set[1] = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                    end else if (!(^{shift_q, par_q})) begin
                        err_set[0] = 1'b1;
`endif
                    end else begin
                        push_d      = 1'b1;
                        push_data_d = shift_q;
                    end
                end
            endcase
        end else if (state_q != ST_IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d    = ST_IDLE;
            to_cnt_d   = '0;
            err_set[1] = 1'b1;
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        full       = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                     (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
        pop        = rd_valid_q && bus.rd_ready;
        wr_en      = push_q && (!full || pop);
        ovf        = push_q && full && !pop;
        wr_ptr_d   = wr_ptr_q + {{FIFO_AW{1'b0}}, wr_en};
        rd_ptr_d   = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
        rd_valid_d = (wr_ptr_q != rd_ptr_d);
        rd_data_d  = mem_q[rd_ptr_d[FIFO_AW-1:0]];
        err_d      = bus.err_clear ? 3'b000 : (err_q | err_set | {ovf, 2'b00});
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data_q;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            ps2_clk_s1_q <= 1'b1;
            ps2_clk_s2_q <= 1'b1;
            ps2_dat_s1_q <= 1'b1;
            ps2_dat_s2_q <= 1'b1;
            filt_q       <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            to_cnt_q     <= '0;
            push_q       <= 1'b0;
            push_data_q  <= 8'h00;
            err_q        <= 3'b000;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= 8'h00;
        end else begin
            ps2_clk_s1_q <= bus.ps2_clk;
            ps2_clk_s2_q <= ps2_clk_s1_q;
            ps2_dat_s1_q <= bus.ps2_data;
            ps2_dat_s2_q <= ps2_dat_s1_q;
            filt_q       <= filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            to_cnt_q     <= to_cnt_d;
            push_q       <= push_d;
            push_data_q  <= push_data_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.err_status = err_q;
endmodule
